// File: rtl/mdu_core_if.sv
// Bundle of the EX-stage signals shared by the decoder/forwarding side and the
// multiply/divide unit. The master drives the instruction, and the slave is the MDU.
interface mdu_core_if;
  logic        start;
  logic [4:0]  mdu_op;
  logic        cancel;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  modport master (
    output start, mdu_op, cancel, rs_val, rt_val,
    input  busy, hi, lo, rd_data
  );

  modport slave (
    input  start, mdu_op, cancel, rs_val, rt_val,
    output busy, hi, lo, rd_data
  );
endinterface

// File: rtl/mdu_core.sv
// Multiply/divide unit for the EX stage. It holds the architectural HI/LO pair.
// The result of a mult/div is computed when the instruction is accepted and
// parked in pending registers. A down-counter then holds busy high for the
// configured latency. Only after that does the result commit to HI/LO, so the
// visible timing matches a real iterative unit.
module mdu_core #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  mdu_core_if.slave  bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  localparam logic [4:0] OP_MULT  = 5'd1;
  localparam logic [4:0] OP_MULTU = 5'd2;
  localparam logic [4:0] OP_DIV   = 5'd3;
  localparam logic [4:0] OP_DIVU  = 5'd4;
  localparam logic [4:0] OP_MFHI  = 5'd5;
  localparam logic [4:0] OP_MFLO  = 5'd6;
  localparam logic [4:0] OP_MTHI  = 5'd7;
  localparam logic [4:0] OP_MTLO  = 5'd8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic             pend_wr_q, pend_wr_d;

  logic accept;
  logic is_mult, is_multu, is_div, is_divu, is_mthi, is_mtlo;
  logic is_mul_class, is_div_class;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;

  logic        rs_neg, rt_neg, div_by_zero;
  logic [31:0] mag_rs, mag_rt, quo_mag, rem_mag, quotient, remainder;

  logic [31:0] res_hi, res_lo;
  logic        res_wr;

  // Decode the EX instruction. A new instruction is accepted only while idle and not flushed.
  always_comb begin
    accept       = bus.start & ~bus.cancel & (state_q == ST_IDLE);
    is_mult      = accept & (bus.mdu_op == OP_MULT);
    is_multu     = accept & (bus.mdu_op == OP_MULTU);
    is_div       = accept & (bus.mdu_op == OP_DIV);
    is_divu      = accept & (bus.mdu_op == OP_DIVU);
    is_mthi      = accept & (bus.mdu_op == OP_MTHI);
    is_mtlo      = accept & (bus.mdu_op == OP_MTLO);
    is_mul_class = is_mult | is_multu;
    is_div_class = is_div | is_divu;
  end

  // Full 64-bit products, sign- or zero-extended operands so a single wide multiply covers both.
  always_comb begin
    prod_s = $signed({{32{bus.rs_val[31]}}, bus.rs_val}) *
             $signed({{32{bus.rt_val[31]}}, bus.rt_val});
    prod_u = {32'd0, bus.rs_val} * {32'd0, bus.rt_val};
  end

  // Signed division as an unsigned divide of magnitudes with sign fix-up.
  // This truncates toward zero and gives the remainder the sign of the dividend.
  // For 0x80000000 / -1, the magnitude 0x80000000 negates back to itself, which is the wanted result.
  always_comb begin
    rs_neg      = (bus.mdu_op == OP_DIV) & bus.rs_val[31];
    rt_neg      = (bus.mdu_op == OP_DIV) & bus.rt_val[31];
    div_by_zero = (bus.rt_val == 32'd0);
    mag_rs      = rs_neg ? (~bus.rs_val + 32'd1) : bus.rs_val;
    mag_rt      = rt_neg ? (~bus.rt_val + 32'd1) : bus.rt_val;
    if (div_by_zero) begin
      quo_mag = 32'd0;
      rem_mag = 32'd0;
    end else begin
      quo_mag = mag_rs / mag_rt;
      rem_mag = mag_rs % mag_rt;
    end
    quotient  = (rs_neg ^ rt_neg) ? (~quo_mag + 32'd1) : quo_mag;
    remainder = rs_neg ? (~rem_mag + 32'd1) : rem_mag;
  end

  // Choose the pending result for the accepted long op. A zero divisor still burns the cycles but never writes.
  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    res_wr = 1'b0;
    if (is_mult) begin
      res_hi = prod_s[63:32];
      res_lo = prod_s[31:0];
      res_wr = 1'b1;
    end else if (is_multu) begin
      res_hi = prod_u[63:32];
      res_lo = prod_u[31:0];
      res_wr = 1'b1;
    end else if (is_div_class) begin
      res_hi = remainder;
      res_lo = quotient;
      res_wr = ~div_by_zero;
    end
  end

  // IDLE/BUSY sequencing: launch long ops, execute mthi/mtlo at once, commit pending results when the count expires.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      ST_IDLE: begin
        if (is_mul_class | is_div_class) begin
          pend_hi_d = res_hi;
          pend_lo_d = res_lo;
          pend_wr_d = res_wr;
          count_d   = is_mul_class ? MULT_LOAD : DIV_LOAD;
          state_d   = ST_BUSY;
        end else if (is_mthi) begin
          hi_d = bus.rs_val;
        end else if (is_mtlo) begin
          lo_d = bus.rs_val;
        end
      end
      ST_BUSY: begin
        if (count_q == '0) begin
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          pend_wr_d = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers. Reset drops any op in flight and clears HI/LO immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  // Outputs: busy comes straight from the state flop, and rd_data is a combinational move-from read.
  always_comb begin
    bus.busy = (state_q == ST_BUSY);
    bus.hi   = hi_q;
    bus.lo   = lo_q;
    case (bus.mdu_op)
      OP_MFHI: bus.rd_data = hi_q;
      OP_MFLO: bus.rd_data = lo_q;
      default: bus.rd_data = 32'd0;
    endcase
  end

endmodule
